// File: rtl/ps2_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and the
// frame parity helper.
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RTS,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_REL
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] BRK         = 8'hF0;

  // PS/2 frames carry odd parity: the 9 bits {parity, data} hold an odd count of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Command/status bundle between a host controller and the PS/2 transmitter.
interface ps2_tx_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;
  logic       timeout_err;

  modport master (output wr_ps2, output din,
                  input tx_idle, input tx_done_tick, input ack_err, input timeout_err);
  modport slave  (input wr_ps2, input din,
                  output tx_idle, output tx_done_tick, output ack_err, output timeout_err);
endinterface

// File: rtl/ps2_clk_filter.sv
// PS/2 clock deglitcher: the level only changes after FILTER_LEN identical
// samples; fall_tick pulses one cycle on each filtered 1->0 transition.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  output logic level,
  output logic fall_tick
);

  logic [FILTER_LEN-1:0] sh_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_p0     <= '1;
      level     <= 1'b1;
      fall_tick <= 1'b0;
    end else begin
      sh_p0     <= {ps2c, sh_p0[FILTER_LEN-1:1]};
      fall_tick <= 1'b0;
      if (&sh_p0) begin
        level <= 1'b1;
      end else if (~|sh_p0) begin
        level     <= 1'b0;
        fall_tick <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, then 8 data bits, odd
// parity and stop clocked out by the device, with ack check and timeout.
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic     clk,
  input  logic     reset,
  ps2_tx_if.slave  bus,
  inout  tri       ps2c,
  inout  tri       ps2d
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] ILAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

  ps2_state_t    state, state_n;
  logic [8:0]    b, b_n;
  logic [3:0]    n, n_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          ack_err, ack_n;
  logic          timeout_err, to_n;
  logic          done_tick, done_n;
  logic          ps2d_p0, ps2d_p1;
  logic          c_level, fall_tick;
  logic          timed_state;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .level     (c_level),
    .fall_tick (fall_tick)
  );

  // Line drivers decode straight from state so an async reset releases them at once.
  assign ps2c = (state == ST_RTS) ? 1'b0 : 1'bz;
  assign ps2d = ((state == ST_START) || (state == ST_DATA && !b[0])) ? 1'b0 : 1'bz;

  assign bus.tx_idle      = (state == ST_IDLE);
  assign bus.tx_done_tick = done_tick;
  assign bus.ack_err      = ack_err;
  assign bus.timeout_err  = timeout_err;

  assign timed_state = (state == ST_START) || (state == ST_DATA) ||
                       (state == ST_STOP)  || (state == ST_WAIT_REL);

  always_comb begin
    state_n = state;
    b_n     = b;
    n_n     = n;
    icnt_n  = icnt;
    tcnt_n  = tcnt;
    ack_n   = ack_err;
    to_n    = timeout_err;
    done_n  = 1'b0;

    if (timed_state) begin
      if (fall_tick)         tcnt_n = '0;
      else if (tcnt != TMAX) tcnt_n = tcnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (bus.wr_ps2) begin
          b_n     = {odd_parity(bus.din), bus.din};
          ack_n   = 1'b0;
          to_n    = 1'b0;
          icnt_n  = '0;
          state_n = ST_RTS;
        end
      end
      ST_RTS: begin
        if (icnt == ILAST) begin
          tcnt_n  = '0;
          state_n = ST_START;
        end else begin
          icnt_n = icnt + 1'b1;
        end
      end
      ST_START: begin
        if (fall_tick) begin
          n_n     = 4'd8;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fall_tick) begin
          if (n == 4'd0) begin
            state_n = ST_STOP;
          end else begin
            b_n = {1'b0, b[8:1]};
            n_n = n - 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (fall_tick) begin
          ack_n   = ps2d_p1;
          state_n = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (c_level && ps2d_p1) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A device edge in the same cycle keeps the transfer alive.
    if (timed_state && !fall_tick && tcnt >= TLAST) begin
      to_n    = 1'b1;
      done_n  = 1'b1;
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      n           <= '0;
      icnt        <= '0;
      tcnt        <= '0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
      done_tick   <= 1'b0;
      ps2d_p0     <= 1'b1;
      ps2d_p1     <= 1'b1;
    end else begin
      state       <= state_n;
      n           <= n_n;
      icnt        <= icnt_n;
      tcnt        <= tcnt_n;
      ack_err     <= ack_n;
      timeout_err <= to_n;
      done_tick   <= done_n;
      ps2d_p0     <= ps2d;
      ps2d_p1     <= ps2d_p0;
    end
  end

  always_ff @(posedge clk) begin
    b <= b_n;
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a behavioural PS/2 keyboard on pulled-up lines
// and a frame scoreboard.
module tb_ps2_tx;
  import ps2_tx_pkg::*;

  localparam int INH = 50;
  localparam int TO  = 300;
  localparam int FL  = 8;
  localparam int H   = 40;

  logic clk = 1'b0;
  logic reset;
  tri1  ps2c;
  tri1  ps2d;
  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;

  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  ps2_tx_if bus();

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .ps2c  (ps2c),
    .ps2d  (ps2d)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ticks = 0;
  int inh_low;
  int ticks0;
  int c0;
  int t;
  logic [10:0] exp_q[$];
  logic [10:0] fr;
  logic [10:0] exp_fr;
  bit          ok;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.tx_done_tick === 1'b1) ticks <= ticks + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    bus.din    = d;
    bus.wr_ps2 = 1'b1;
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
  endtask

  // Waits for request-to-send, measures the inhibit, then clocks 11 bits.
  task automatic device_run(input bit ack, input bit glitch,
                            output logic [10:0] frame, output bit good);
    int w;
    good  = 1'b1;
    frame = '0;
    w = 0;
    while (ps2c !== 1'b0 && w < 200) begin @(negedge clk); w++; end
    if (ps2c !== 1'b0) begin good = 1'b0; return; end
    w = 0;
    while (ps2c === 1'b0 && w < INH + 50) begin @(negedge clk); w++; end
    inh_low = w;
    repeat (20) @(negedge clk);
    frame[0] = ps2d;
    for (int k = 1; k <= 11; k++) begin
      dev_c_low = 1'b1;
      if (k == 11 && ack) dev_d_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_c_low = 1'b0;
      repeat (H / 2) @(negedge clk);
      if (k <= 10) frame[k] = ps2d;
      if (glitch && k == 4) begin
        dev_c_low = 1'b1;
        repeat (4) @(negedge clk);
        dev_c_low = 1'b0;
      end
      repeat (H / 2) @(negedge clk);
    end
    dev_d_low = 1'b0;
  endtask

  task automatic full_tx(input string tag, input logic [7:0] d, input bit ack, input bit glitch);
    ticks0 = ticks;
    exp_q.push_back(frame_of(d));
    fork
      start_tx(d);
      device_run(ack, glitch, fr, ok);
    join
    repeat (20) @(negedge clk);
    check({tag, "_dev_ok"}, 32'(ok), 32'd1);
    check({tag, "_inhibit"}, 32'(inh_low >= INH), 32'd1);
    exp_fr = exp_q.pop_front();
    check({tag, "_frame"}, 32'(fr), 32'(exp_fr));
    check({tag, "_ticks"}, 32'(ticks - ticks0), 32'd1);
    check({tag, "_ack_err"}, 32'(bus.ack_err), 32'(!ack));
    check({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
    check({tag, "_idle"}, 32'(bus.tx_idle), 32'd1);
    check({tag, "_ps2c_rel"}, 32'(ps2c), 32'd1);
    check({tag, "_ps2d_rel"}, 32'(ps2d), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle", 32'(bus.tx_idle), 32'd1);
    check("rst_done", 32'(bus.tx_done_tick), 32'd0);
    check("rst_ack_err", 32'(bus.ack_err), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("rst_ps2c", 32'(ps2c), 32'd1);
    check("rst_ps2d", 32'(ps2d), 32'd1);

    full_tx("led", CMD_SET_LED, 1'b1, 1'b0);
    full_tx("par01", 8'h01, 1'b1, 1'b0);
    full_tx("par00", 8'h00, 1'b1, 1'b0);
    full_tx("nack", CMD_RESET, 1'b0, 1'b0);
    full_tx("glitch", BRK, 1'b1, 1'b1);

    // Second write mid-transfer must not disturb the frame in flight.
    ticks0 = ticks;
    exp_q.push_back(frame_of(CMD_ENABLE));
    fork
      start_tx(CMD_ENABLE);
      device_run(1'b1, 1'b0, fr, ok);
      begin
        repeat (300) @(negedge clk);
        check("busy_not_idle", 32'(bus.tx_idle), 32'd0);
        bus.din    = 8'hAA;
        bus.wr_ps2 = 1'b1;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    exp_fr = exp_q.pop_front();
    check("busy_frame", 32'(fr), 32'(exp_fr));
    check("busy_ticks", 32'(ticks - ticks0), 32'd1);
    check("busy_idle", 32'(bus.tx_idle), 32'd1);

    // Silent device: timeout measured from the end of request-to-send.
    ticks0 = ticks;
    start_tx(8'h3C);
    t = 0;
    while (ps2c !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (ps2c === 1'b0 && t < INH + 50) begin @(negedge clk); t++; end
    c0 = cyc;
    t = 0;
    while (bus.tx_done_tick !== 1'b1 && t < TO + 50) begin @(negedge clk); t++; end
    check("to_seen", 32'(bus.tx_done_tick), 32'd1);
    check("to_latency", 32'(cyc - c0), 32'(TO));
    check("to_timeout_err", 32'(bus.timeout_err), 32'd1);
    check("to_ack_err", 32'(bus.ack_err), 32'd0);
    check("to_idle", 32'(bus.tx_idle), 32'd1);
    check("to_ps2c_rel", 32'(ps2c), 32'd1);
    check("to_ps2d_rel", 32'(ps2d), 32'd1);
    repeat (5) @(negedge clk);
    check("to_ticks", 32'(ticks - ticks0), 32'd1);

    // Reset while the host is driving a 0 data bit.
    start_tx(RSP_ACK);
    t = 0;
    while (ps2c !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (ps2c === 1'b0 && t < INH + 50) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      dev_c_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_c_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    check("mid_busy", 32'(bus.tx_idle), 32'd0);
    check("mid_ps2d_low", 32'(ps2d), 32'd0);
    #3 reset = 1'b1;
    #1;
    check("arst_ps2c", 32'(ps2c), 32'd1);
    check("arst_ps2d", 32'(ps2d), 32'd1);
    check("arst_idle", 32'(bus.tx_idle), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("arst_done", 32'(bus.tx_done_tick), 32'd0);
    check("arst_ack_err", 32'(bus.ack_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
